branch_sequencer: RTL and testbench
===================================

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 instr_valid  input  1  a decoded instruction is present.
REQ-005 instr_ready  output  1  the sequencer can accept an instruction.
REQ-006 op  input  3  opcode:
- 000 NOP
- 001 JMP
- 010 JCOND
- 011 CALL
- 100 RET
- 101 HALT
- 110/111 illegal
REQ-007 cond  input  2  JCOND condition:
- 00 always
- 01 Z
- 10 C
- 11 not Z
REQ-008 target  input  8  jump/call destination address.
REQ-009 flag_z, flag_c  input  1 each  ALU flags, sampled at acceptance.
REQ-010 resume  input  1  leave HALT.
REQ-011 pc_cmd_valid  output  1  one-cycle strobe; the program counter SHALL apply pc_mode only when this is high.
REQ-012 pc_mode  output  2  PC command:
- 00 step
- 01 load
- 10 pop
- 11 push-and-load
REQ-013 pc_data  output  8  load/call address.
REQ-014 depth  output  6  return-stack occupancy, 0..32.
REQ-015 fault  output  1  sticky fault flag.
REQ-016 fault_code  output  2  fault cause:
- 00 none
- 01 overflow
- 10 underflow
- 11 illegal op

Function
REQ-017 An instruction SHALL be accepted on any rising edge where instr_valid and instr_ready are both 1.
REQ-018 The FSM SHALL have four states: RUN, ISSUE, HALT, FAULT.
REQ-019 instr_ready SHALL be 1 only in RUN.
REQ-020 The FSM SHALL leave RUN only when an instruction is accepted, and SHALL stay in RUN otherwise.
REQ-021 On accepting NOP, JMP, JCOND, CALL or RET with no fault, the FSM SHALL move RUN->ISSUE; in ISSUE, pc_cmd_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to RUN.
REQ-022 Throughput SHALL be at most one instruction per 2 cycles; the command SHALL appear 1 cycle after acceptance.
REQ-023 The command in ISSUE SHALL be:
- NOP: mode 00.
- JMP: mode 01, pc_data=target.
- JCOND taken: mode 01, pc_data=target.
- JCOND not taken: mode 00.
- CALL: mode 11, pc_data=target.
- RET: mode 10.
REQ-024 The JCOND condition SHALL be evaluated on the flag values registered at acceptance; flag changes after acceptance SHALL have no effect.
REQ-025 depth SHALL increment by 1 on an issued CALL, decrement by 1 on an issued RET, and be unchanged otherwise; it SHALL update on the ISSUE edge.
REQ-026 Accepting HALT SHALL move RUN->HALT with no PC command issued.
REQ-027 In HALT, resume=1 SHALL move HALT->RUN on the next edge; resume SHALL be ignored in all other states.
REQ-028 Accepting an illegal op SHALL move RUN->FAULT with fault=1, fault_code=11, and no command issued.
REQ-029 FAULT SHALL be terminal until reset; instr_ready SHALL be 0 and pc_cmd_valid SHALL be 0 while in FAULT.
REQ-030 Outside ISSUE, pc_cmd_valid SHALL be 0, pc_mode SHALL be 00, and pc_data SHALL hold its last value.

Reset
REQ-031 While rst=0, the block SHALL immediately (asynchronously) force:
- state=RUN
- pc_cmd_valid=0
- pc_mode=00
- pc_data=00
- depth=0
- fault=0
- fault_code=00
- registered flags=0
REQ-032 A reset asserted during ISSUE SHALL abort the pending command; no strobe SHALL occur after reset is released.
REQ-033 instr_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-034 Macro SEQ_STACK_GUARD_EN defined: CALL accepted at depth=32 SHALL enter FAULT with fault_code=01, and RET at depth=0 SHALL enter FAULT with fault_code=10; no command SHALL be issued and depth SHALL be unchanged.
REQ-035 Macro SEQ_STACK_GUARD_EN undefined: no depth tracking logic SHALL exist, depth SHALL read constant 0, CALL/RET SHALL always issue, and fault codes 01/10 SHALL never occur (illegal-op fault is retained).

Verification
REQ-036 Reset, then op=001 target=8'h3C accepted -> next cycle: pc_cmd_valid=1, pc_mode=01, pc_data=3C; following cycle: instr_ready=1.
REQ-037 op=010 cond=01 with flag_z=0 -> pc_mode=00; repeat with flag_z=1, target=8'h80 -> pc_mode=01, pc_data=80.
REQ-038 Three CALLs then two RETs -> depth sequence 1,2,3,2,1; modes 11,11,11,10,10.
REQ-039 With guard enabled: 32 CALLs then a 33rd -> fault=1, fault_code=01, depth=32, no strobe, instr_ready=0 until rst; RET at depth 0 after reset -> fault_code=10.
REQ-040 op=101 -> no strobe, instr_ready=0 for 5 cycles; resume pulse -> instr_ready=1 on the next cycle; op=111 -> fault_code=11.
REQ-041 rst asserted in the ISSUE cycle of a CALL -> outputs clear immediately, depth=0, no strobe after release.

Source files
------------

// File: rtl/branch_sequencer.sv
// ----------------------------------------------------------------------------
// branch_sequencer
//
// Control-flow sequencer sitting between the instruction decoder and the
// program counter. It accepts one decoded instruction at a time, turns it
// into a single-cycle PC command strobe, tracks return-stack occupancy and
// latches a sticky fault on illegal opcodes (and, optionally, on stack
// overflow/underflow).
//
// Optional feature macro: SEQ_STACK_GUARD_EN
//   defined   : depth is tracked; CALL at depth 32 faults with code 01 and
//               RET at depth 0 faults with code 10 (no command issued).
//   undefined : no depth tracking; depth reads 0; CALL/RET always issue.
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous active-low reset
//   instr_valid  in   1  decoded instruction present
//   instr_ready  out  1  sequencer can accept (only in RUN)
//   op           in   3  000 NOP, 001 JMP, 010 JCOND, 011 CALL, 100 RET,
//                        101 HALT, 110/111 illegal
//   cond         in   2  JCOND condition: 00 always, 01 Z, 10 C, 11 not Z
//   target       in   8  jump/call destination
//   flag_z       in   1  ALU zero flag, sampled at acceptance
//   flag_c       in   1  ALU carry flag, sampled at acceptance
//   resume       in   1  leave HALT
//   pc_cmd_valid out  1  one-cycle PC command strobe
//   pc_mode      out  2  00 step, 01 load, 10 pop, 11 push-and-load
//   pc_data      out  8  load/call address (holds between commands)
//   depth        out  6  return-stack occupancy 0..32
//   fault        out  1  sticky fault flag
//   fault_code   out  2  00 none, 01 overflow, 10 underflow, 11 illegal op
// ----------------------------------------------------------------------------
module branch_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] op,
    input  logic [1:0] cond,
    input  logic [7:0] target,
    input  logic       flag_z,
    input  logic       flag_c,
    input  logic       resume,
    output logic       pc_cmd_valid,
    output logic [1:0] pc_mode,
    output logic [7:0] pc_data,
    output logic [5:0] depth,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam logic [2:0] OpNop   = 3'b000;
    localparam logic [2:0] OpJmp   = 3'b001;
    localparam logic [2:0] OpJcond = 3'b010;
    localparam logic [2:0] OpCall  = 3'b011;
    localparam logic [2:0] OpRet   = 3'b100;
    localparam logic [2:0] OpHalt  = 3'b101;

    localparam logic [1:0] ModeStep     = 2'b00;
    localparam logic [1:0] ModeLoad     = 2'b01;
    localparam logic [1:0] ModePop      = 2'b10;
    localparam logic [1:0] ModePushLoad = 2'b11;

    localparam logic [1:0] FaultNone      = 2'b00;
    localparam logic [1:0] FaultOverflow  = 2'b01;
    localparam logic [1:0] FaultUnderflow = 2'b10;
    localparam logic [1:0] FaultIllegal   = 2'b11;

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StIssue = 2'b01,
        StHalt  = 2'b10,
        StFault = 2'b11
    } state_e;

    state_e state_q;
    logic   accept;
    logic   cond_taken;
    logic   stack_full;
    logic   stack_empty;

    assign instr_ready = (state_q == StRun);
    assign accept      = instr_valid & instr_ready;

    // The branch decision is taken from the flags present on the accepting
    // edge and frozen into pc_mode, so later flag movement cannot alter it.
    always_comb begin
        cond_taken = 1'b0;
        unique case (cond)
            2'b00: cond_taken = 1'b1;
            2'b01: cond_taken = flag_z;
            2'b10: cond_taken = flag_c;
            2'b11: cond_taken = ~flag_z;
        endcase
    end

`ifdef SEQ_STACK_GUARD_EN
    localparam logic [5:0] DepthMax = 6'd32;

    logic [5:0] depth_q;

    assign stack_full  = (depth_q == DepthMax);
    assign stack_empty = (depth_q == 6'd0);
    assign depth       = depth_q;

    // Occupancy moves on the edge that leaves ISSUE, using the command that
    // was actually strobed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth_q <= 6'd0;
        end else if (state_q == StIssue) begin
            if (pc_mode == ModePushLoad) begin
                depth_q <= depth_q + 6'd1;
            end else if (pc_mode == ModePop) begin
                depth_q <= depth_q - 6'd1;
            end
        end
    end
`else
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b0;
    assign depth       = 6'd0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StRun;
            pc_cmd_valid <= 1'b0;
            pc_mode      <= ModeStep;
            pc_data      <= 8'h00;
            fault        <= 1'b0;
            fault_code   <= FaultNone;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (accept) begin
                        if (op == OpHalt) begin
                            state_q <= StHalt;
                        end else if (op > OpHalt) begin
                            state_q    <= StFault;
                            fault      <= 1'b1;
                            fault_code <= FaultIllegal;
                        end else if ((op == OpCall) && stack_full) begin
                            state_q    <= StFault;
                            fault      <= 1'b1;
                            fault_code <= FaultOverflow;
                        end else if ((op == OpRet) && stack_empty) begin
                            state_q    <= StFault;
                            fault      <= 1'b1;
                            fault_code <= FaultUnderflow;
                        end else begin
                            // Command registered here appears during ISSUE.
                            state_q      <= StIssue;
                            pc_cmd_valid <= 1'b1;
                            case (op)
                                OpJmp: begin
                                    pc_mode <= ModeLoad;
                                    pc_data <= target;
                                end
                                OpJcond: begin
                                    if (cond_taken) begin
                                        pc_mode <= ModeLoad;
                                        pc_data <= target;
                                    end else begin
                                        pc_mode <= ModeStep;
                                    end
                                end
                                OpCall: begin
                                    pc_mode <= ModePushLoad;
                                    pc_data <= target;
                                end
                                OpRet: begin
                                    pc_mode <= ModePop;
                                end
                                default: begin
                                    pc_mode <= ModeStep;
                                end
                            endcase
                        end
                    end
                end
                StIssue: begin
                    // pc_data is deliberately left holding the last address.
                    state_q      <= StRun;
                    pc_cmd_valid <= 1'b0;
                    pc_mode      <= ModeStep;
                end
                StHalt: begin
                    if (resume) begin
                        state_q <= StRun;
                    end
                end
                StFault: begin
                    state_q <= StFault;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_branch_sequencer
//
// Table-driven bench for branch_sequencer: a vector table of instructions
// with hand-computed PC commands and depths, followed by hand-written
// sequences for HALT/resume, illegal ops, reset during ISSUE and (when
// SEQ_STACK_GUARD_EN is defined) stack overflow/underflow.
// ----------------------------------------------------------------------------
module tb_branch_sequencer;

`ifdef SEQ_STACK_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] op;
    logic [1:0] cond;
    logic [7:0] target;
    logic       flag_z;
    logic       flag_c;
    logic       resume;
    logic       pc_cmd_valid;
    logic [1:0] pc_mode;
    logic [7:0] pc_data;
    logic [5:0] depth;
    logic       fault;
    logic [1:0] fault_code;

    int vectors;
    int miscompares;

    branch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .op           (op),
        .cond         (cond),
        .target       (target),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .resume       (resume),
        .pc_cmd_valid (pc_cmd_valid),
        .pc_mode      (pc_mode),
        .pc_data      (pc_data),
        .depth        (depth),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [1:0] cond;
        logic [7:0] target;
        logic       fz;
        logic       fc;
        logic [1:0] exp_mode;
        logic [7:0] exp_data;
        logic [5:0] exp_depth;  // occupancy with the guard enabled
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [2:0] o, input logic [1:0] c, input logic [7:0] t,
                        input logic fz, input logic fc);
        instr_valid = 1'b1;
        op          = o;
        cond        = c;
        target      = t;
        flag_z      = fz;
        flag_c      = fc;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        // Flip flags after acceptance; the issued command must not follow them.
        flag_z      = ~fz;
        flag_c      = ~fc;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input vec_t v);
        logic [5:0] exp_d;
        exp_d = Guard ? v.exp_depth : 6'd0;
        check({v.name, " ready"}, {31'd0, instr_ready}, 32'd1);
        send(v.op, v.cond, v.target, v.fz, v.fc);
        check({v.name, " strobe"}, {31'd0, pc_cmd_valid}, 32'd1);
        check({v.name, " mode"}, {30'd0, pc_mode}, {30'd0, v.exp_mode});
        check({v.name, " data"}, {24'd0, pc_data}, {24'd0, v.exp_data});
        @(posedge clk);
        #1;
        check({v.name, " strobe off"}, {31'd0, pc_cmd_valid}, 32'd0);
        check({v.name, " mode idle"}, {30'd0, pc_mode}, 32'd0);
        check({v.name, " data hold"}, {24'd0, pc_data}, {24'd0, v.exp_data});
        check({v.name, " depth"}, {26'd0, depth}, {26'd0, exp_d});
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b0;
        instr_valid  = 1'b0;
        op           = 3'b000;
        cond         = 2'b00;
        target       = 8'h00;
        flag_z       = 1'b0;
        flag_c       = 1'b0;
        resume       = 1'b0;

        //          name        op      cond   tgt    fz    fc    mode   data   depth
        vecs[0]  = '{"jmp",      3'd1, 2'd0, 8'h3C, 1'b0, 1'b0, 2'd1, 8'h3C, 6'd0};
        vecs[1]  = '{"jz_nt",    3'd2, 2'd1, 8'h99, 1'b0, 1'b0, 2'd0, 8'h3C, 6'd0};
        vecs[2]  = '{"jz_t",     3'd2, 2'd1, 8'h80, 1'b1, 1'b0, 2'd1, 8'h80, 6'd0};
        vecs[3]  = '{"jalways",  3'd2, 2'd0, 8'h11, 1'b0, 1'b0, 2'd1, 8'h11, 6'd0};
        vecs[4]  = '{"jc_nt",    3'd2, 2'd2, 8'h22, 1'b1, 1'b0, 2'd0, 8'h11, 6'd0};
        vecs[5]  = '{"jc_t",     3'd2, 2'd2, 8'h22, 1'b0, 1'b1, 2'd1, 8'h22, 6'd0};
        vecs[6]  = '{"jnz_nt",   3'd2, 2'd3, 8'h33, 1'b1, 1'b1, 2'd0, 8'h22, 6'd0};
        vecs[7]  = '{"jnz_t",    3'd2, 2'd3, 8'h33, 1'b0, 1'b0, 2'd1, 8'h33, 6'd0};
        vecs[8]  = '{"nop",      3'd0, 2'd0, 8'h44, 1'b0, 1'b0, 2'd0, 8'h33, 6'd0};
        vecs[9]  = '{"call1",    3'd3, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd3, 8'hA0, 6'd1};
        vecs[10] = '{"call2",    3'd3, 2'd0, 8'hA1, 1'b0, 1'b0, 2'd3, 8'hA1, 6'd2};
        vecs[11] = '{"call3",    3'd3, 2'd0, 8'hA2, 1'b0, 1'b0, 2'd3, 8'hA2, 6'd3};
        vecs[12] = '{"ret1",     3'd4, 2'd0, 8'h55, 1'b0, 1'b0, 2'd2, 8'hA2, 6'd2};
        vecs[13] = '{"ret2",     3'd4, 2'd0, 8'h56, 1'b0, 1'b0, 2'd2, 8'hA2, 6'd1};
        vecs[14] = '{"ret3",     3'd4, 2'd0, 8'h57, 1'b0, 1'b0, 2'd2, 8'hA2, 6'd0};

        // Reset state, both while held and once released.
        #12;
        check("rst pc_cmd_valid", {31'd0, pc_cmd_valid}, 32'd0);
        check("rst pc_mode", {30'd0, pc_mode}, 32'd0);
        check("rst pc_data", {24'd0, pc_data}, 32'd0);
        check("rst depth", {26'd0, depth}, 32'd0);
        check("rst fault", {31'd0, fault}, 32'd0);
        check("rst fault_code", {30'd0, fault_code}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("ready after release", {31'd0, instr_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("ready first cycle", {31'd0, instr_ready}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            apply_vec(vecs[i]);
        end

        // HALT: no strobe and not ready while halted, even with a pending instruction.
        send(3'd5, 2'd0, 8'h77, 1'b0, 1'b0);
        instr_valid = 1'b1;
        op          = 3'd1;
        for (int i = 0; i < 5; i++) begin
            check("halt ready", {31'd0, instr_ready}, 32'd0);
            check("halt strobe", {31'd0, pc_cmd_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        instr_valid = 1'b0;
        check("halt data hold", {24'd0, pc_data}, 32'h000000A2);
        resume = 1'b1;
        @(posedge clk);
        #1;
        resume = 1'b0;
        check("resume ready", {31'd0, instr_ready}, 32'd1);
        check("resume no strobe", {31'd0, pc_cmd_valid}, 32'd0);

        // Return with an empty stack: issues when unguarded, faults when guarded.
        send(3'd4, 2'd0, 8'h00, 1'b0, 1'b0);
        check("ret empty strobe", {31'd0, pc_cmd_valid}, Guard ? 32'd0 : 32'd1);
        check("ret empty fault", {31'd0, fault}, Guard ? 32'd1 : 32'd0);
        check("ret empty code", {30'd0, fault_code}, Guard ? 32'd2 : 32'd0);
        check("ret empty depth", {26'd0, depth}, 32'd0);
        @(posedge clk);
        #1;
        check("ret empty ready", {31'd0, instr_ready}, Guard ? 32'd0 : 32'd1);
        do_reset();

        // Reset asserted in the ISSUE cycle of a CALL aborts the command.
        send(3'd3, 2'd0, 8'hC5, 1'b0, 1'b0);
        check("issue strobe pre-rst", {31'd0, pc_cmd_valid}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("abort strobe", {31'd0, pc_cmd_valid}, 32'd0);
        check("abort mode", {30'd0, pc_mode}, 32'd0);
        check("abort data", {24'd0, pc_data}, 32'd0);
        check("abort depth", {26'd0, depth}, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post-abort strobe", {31'd0, pc_cmd_valid}, 32'd0);
            check("post-abort ready", {31'd0, instr_ready}, 32'd1);
            check("post-abort depth", {26'd0, depth}, 32'd0);
        end

        // Illegal opcodes: terminal fault that ignores resume.
        send(3'd7, 2'd0, 8'h12, 1'b0, 1'b0);
        check("ill7 fault", {31'd0, fault}, 32'd1);
        check("ill7 code", {30'd0, fault_code}, 32'd3);
        check("ill7 strobe", {31'd0, pc_cmd_valid}, 32'd0);
        resume = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("ill7 ready", {31'd0, instr_ready}, 32'd0);
            check("ill7 sticky", {31'd0, fault}, 32'd1);
        end
        resume = 1'b0;
        do_reset();
        check("fault cleared", {31'd0, fault}, 32'd0);
        send(3'd6, 2'd0, 8'h12, 1'b0, 1'b0);
        check("ill6 code", {30'd0, fault_code}, 32'd3);
        check("ill6 strobe", {31'd0, pc_cmd_valid}, 32'd0);
        do_reset();

`ifdef SEQ_STACK_GUARD_EN
        // Fill the stack to 32, then overflow.
        for (int i = 0; i < 32; i++) begin
            send(3'd3, 2'd0, 8'(i), 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        check("full depth", {26'd0, depth}, 32'd32);
        send(3'd3, 2'd0, 8'hEE, 1'b0, 1'b0);
        check("ovf fault", {31'd0, fault}, 32'd1);
        check("ovf code", {30'd0, fault_code}, 32'd1);
        check("ovf strobe", {31'd0, pc_cmd_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("ovf depth", {26'd0, depth}, 32'd32);
            check("ovf ready", {31'd0, instr_ready}, 32'd0);
            check("ovf strobe hold", {31'd0, pc_cmd_valid}, 32'd0);
        end
        do_reset();
        send(3'd4, 2'd0, 8'h00, 1'b0, 1'b0);
        check("unf code", {30'd0, fault_code}, 32'd2);
        check("unf depth", {26'd0, depth}, 32'd0);
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
